// File: rtl/adder_seq.sv
//------------------------------------------------------------------------------
// adder_seq
//
// Multi-cycle adder/subtractor. A single D-bit adder slice is reused for
// N = W/D cycles. The slice works from the least significant digit upwards and
// builds the W-bit result in a shift register. Subtraction is performed as
// a + ~b + 1.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   reset    in   1  asynchronous, active-high reset
//   start    in   1  request a new operation (sampled only while idle)
//   op       in   1  0: add, 1: subtract
//   a, b     in   W  operands, captured on the accepting edge
//   cin      in   1  carry in for add (ignored for subtract)
//   s        out  W  registered result
//   cout     out  1  carry out (subtract: 1 = no borrow)
//   ovf      out  1  two's-complement overflow
//   busy     out  1  operation in progress
//   done     out  1  one-cycle pulse when s/cout/ovf are updated
//   state_o  out  1  current FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: start is accepted only on a rising edge where busy=0. busy then
// stays high for N cycles. On the edge that finishes the last digit, busy
// drops and done pulses for one cycle. start is ignored while busy.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module adder_seq #(
    parameter int W = 8,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         ovf,
    output logic         busy,
    output logic         done,
    output logic [0:0]   state_o
);
    localparam int N  = W / D;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    if (D < 1 || W < D || (W % D) != 0) begin : g_bad_param
        $error("adder_seq: W (%0d) must be a positive multiple of D (%0d)", W, D);
    end

    logic [0:0]    state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  s_q, s_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic          done_q, done_d;

    logic [D:0]    dsum;
    logic          msb_cin;
    logic          last;
    logic [W-1:0]  res_full;
    logic [W-1:0]  a_shift;
    logic [W-1:0]  b_shift;

    // One digit of the sum. dsum[D] is the carry into the next digit.
    assign dsum = {1'b0, a_q[D-1:0]} + {1'b0, b_q[D-1:0]} + {{D{1'b0}}, carry_q};

    // The carry that entered the top bit of this digit is recovered from the
    // sum bit: s = a ^ b ^ c, so c = s ^ a ^ b. On the last digit, that top bit
    // is bit W-1 of the result.
    assign msb_cin = dsum[D-1] ^ a_q[D-1] ^ b_q[D-1];
    assign last    = (cnt_q == CW'(N - 1));

    if (D == W) begin : g_single
        assign res_full = dsum[D-1:0];
        assign a_shift  = '0;
        assign b_shift  = '0;
    end else begin : g_multi
        // This register holds the digits finished so far. The newest digit
        // enters at the top, so after the last digit res_full is complete.
        logic [W-D-1:0] sr_q;

        assign res_full = {dsum[D-1:0], sr_q};
        assign a_shift  = {{D{1'b0}}, a_q[W-1:D]};
        assign b_shift  = {{D{1'b0}}, b_q[W-1:D]};

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sr_q <= '0;
            end else if (state_q == RUN) begin
                sr_q <= res_full[W-1:D];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = op ? ~b : b;
                    carry_d = op ? 1'b1 : cin;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d     = a_shift;
                b_d     = b_shift;
                carry_d = dsum[D];
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    s_d     = res_full;
                    cout_d  = dsum[D];
                    ovf_d   = msb_cin ^ dsum[D];
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign s       = s_q;
    assign cout    = cout_q;
    assign ovf     = ovf_q;
    assign done    = done_q;
    assign busy    = (state_q == RUN);
    assign state_o = state_q;

endmodule

// File: tb/tb_adder_seq.sv
`timescale 1ns/1ps
`ifndef NP
`define NP 24
`endif
`ifndef SEED
`define SEED 1
`endif
module tb_adder_seq;
    localparam int NDUT = 6;
    localparam int WS [NDUT] = '{8, 8, 8, 8, 16, 32};
    localparam int DS [NDUT] = '{1, 4, 8, 2, 4, 32};

    typedef struct {
        string       nm;
        int          k;
        bit          op;
        logic [31:0] a;
        logic [31:0] b;
        bit          cin;
        logic [31:0] s;
        bit          cout;
        bit          ovf;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NDUT-1:0] start = '0;
    logic            op = 1'b0;
    logic            cin = 1'b0;
    logic [31:0]     a_in = '0;
    logic [31:0]     b_in = '0;

    logic [7:0]  s0, s1, s2, s3;
    logic [15:0] s4;
    logic [31:0] s5;
    logic [31:0] s_v    [NDUT];
    logic        cout_v [NDUT];
    logic        ovf_v  [NDUT];
    logic        busy_v [NDUT];
    logic        done_v [NDUT];
    logic [0:0]  st_v   [NDUT];

    assign s_v[0] = {24'd0, s0};
    assign s_v[1] = {24'd0, s1};
    assign s_v[2] = {24'd0, s2};
    assign s_v[3] = {24'd0, s3};
    assign s_v[4] = {16'd0, s4};
    assign s_v[5] = s5;

    adder_seq #(.W(8), .D(1)) u_d0 (.clk(clk), .reset(reset), .start(start[0]), .op(op),
        .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin), .s(s0), .cout(cout_v[0]), .ovf(ovf_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .state_o(st_v[0]));
    adder_seq #(.W(8), .D(4)) u_d1 (.clk(clk), .reset(reset), .start(start[1]), .op(op),
        .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin), .s(s1), .cout(cout_v[1]), .ovf(ovf_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .state_o(st_v[1]));
    adder_seq #(.W(8), .D(8)) u_d2 (.clk(clk), .reset(reset), .start(start[2]), .op(op),
        .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin), .s(s2), .cout(cout_v[2]), .ovf(ovf_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .state_o(st_v[2]));
    adder_seq #(.W(8), .D(2)) u_d3 (.clk(clk), .reset(reset), .start(start[3]), .op(op),
        .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin), .s(s3), .cout(cout_v[3]), .ovf(ovf_v[3]),
        .busy(busy_v[3]), .done(done_v[3]), .state_o(st_v[3]));
    adder_seq #(.W(16), .D(4)) u_d4 (.clk(clk), .reset(reset), .start(start[4]), .op(op),
        .a(a_in[15:0]), .b(b_in[15:0]), .cin(cin), .s(s4), .cout(cout_v[4]), .ovf(ovf_v[4]),
        .busy(busy_v[4]), .done(done_v[4]), .state_o(st_v[4]));
    adder_seq #(.W(32), .D(32)) u_d5 (.clk(clk), .reset(reset), .start(start[5]), .op(op),
        .a(a_in), .b(b_in), .cin(cin), .s(s5), .cout(cout_v[5]), .ovf(ovf_v[5]),
        .busy(busy_v[5]), .done(done_v[5]), .state_o(st_v[5]));

    // ---------------- scoreboard ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    function automatic int ns(input int k);
        return WS[k] / DS[k];
    endfunction

    // Reference: plain integer arithmetic on the masked operands.
    // Result packed as {ovf, cout, s[31:0]}.
    function automatic logic [33:0] model(input int w, input bit o, input logic [31:0] aa,
                                          input logic [31:0] bb, input bit ci);
        logic [63:0] m, full, sr;
        logic [31:0] am, bm;
        bit c, v, sa, sb, ss;
        m  = (64'd1 << w) - 64'd1;
        am = aa & m[31:0];
        bm = bb & m[31:0];
        if (!o) begin
            full = {32'd0, am} + {32'd0, bm} + 64'(ci);
            c    = full[w];
        end else begin
            full = {32'd0, am} - {32'd0, bm};
            c    = (am >= bm);
        end
        sr = full & m;
        sa = am[w-1];
        sb = bm[w-1];
        ss = sr[w-1];
        v  = o ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
        return {v, c, sr[31:0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_op(input string nm, input int k, input bit o, input logic [31:0] aa,
                         input logic [31:0] bb, input bit ci, input logic [31:0] es,
                         input bit ec, input bit eo, input bit disturb, input bit rel_reset);
        int cyc;
        bit bad_busy, bad_hold;
        logic [31:0] prev_s;
        @(negedge clk);
        prev_s   = s_v[k];
        op       = o;
        a_in     = aa;
        b_in     = bb;
        cin      = ci;
        start    = '0;
        start[k] = 1'b1;
        if (rel_reset) reset = 1'b0;
        cyc = 0;
        bad_busy = 1'b0;
        bad_hold = 1'b0;
        while (cyc < 100) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (done_v[k] === 1'b1) break;
            if (busy_v[k] !== 1'b1) bad_busy = 1'b1;
            if (s_v[k] !== prev_s) bad_hold = 1'b1;
            if (disturb) begin
                start[k] = ~start[k];
                a_in     = $urandom;
                b_in     = $urandom;
                op       = 1'($urandom);
                cin      = 1'($urandom);
            end else begin
                start = '0;
            end
        end
        start = '0;
        chk({nm, ".latency"}, 64'(cyc), 64'(ns(k) + 1));
        chk({nm, ".busy_run"}, 64'(bad_busy), 64'd0);
        chk({nm, ".s_hold"}, 64'(bad_hold), 64'd0);
        chk({nm, ".busy_at_done"}, 64'(busy_v[k]), 64'd0);
        chk({nm, ".s"}, 64'(s_v[k]), 64'(es));
        chk({nm, ".cout"}, 64'(cout_v[k]), 64'(ec));
        chk({nm, ".ovf"}, 64'(ovf_v[k]), 64'(eo));
        @(posedge clk);
        @(negedge clk);
        chk({nm, ".done_pulse"}, 64'(done_v[k]), 64'd0);
    endtask

    // Back-to-back random operations with start held high throughout.
    task automatic rand_run(input int k, input int np);
        logic [33:0] exp_q[$];
        logic [33:0] got;
        logic [31:0] m;
        int cyc;
        m = (WS[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << WS[k]) - 32'd1);
        @(negedge clk);
        start = '0;
        for (int i = 0; i < np; i++) begin
            op   = 1'($urandom);
            cin  = 1'($urandom);
            a_in = $urandom & m;
            b_in = $urandom & m;
            exp_q.push_back(model(WS[k], op, a_in, b_in, cin));
            start[k] = 1'b1;
            cyc = 0;
            while (cyc < 100) begin
                @(posedge clk);
                @(negedge clk);
                cyc++;
                if (done_v[k] === 1'b1) break;
            end
            got = {ovf_v[k], cout_v[k], s_v[k]};
            chk($sformatf("rand_k%0d_%0d.latency", k, i), 64'(cyc), 64'(ns(k) + 1));
            chk($sformatf("rand_k%0d_%0d.result", k, i), 64'(got), 64'(exp_q.pop_front()));
        end
        start = '0;
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs [12];

    initial begin
        vecs[0]  = '{"add_ff_01",     0, 1'b0, 32'hFF,        32'h01, 1'b0, 32'h00,        1'b1, 1'b0};
        vecs[1]  = '{"sub_05_07",     0, 1'b1, 32'h05,        32'h07, 1'b0, 32'hFE,        1'b0, 1'b0};
        vecs[2]  = '{"sub_80_01",     0, 1'b1, 32'h80,        32'h01, 1'b0, 32'h7F,        1'b1, 1'b1};
        vecs[3]  = '{"d4_add_ff_cin", 1, 1'b0, 32'hFF,        32'h00, 1'b1, 32'h00,        1'b1, 1'b0};
        vecs[4]  = '{"d8_add_ff_cin", 2, 1'b0, 32'hFF,        32'h00, 1'b1, 32'h00,        1'b1, 1'b0};
        vecs[5]  = '{"d2_add_80_80",  3, 1'b0, 32'h80,        32'h80, 1'b0, 32'h00,        1'b1, 1'b1};
        vecs[6]  = '{"w16_sub_0_1",   4, 1'b1, 32'h0000,      32'h0001, 1'b0, 32'hFFFF,    1'b0, 1'b0};
        vecs[7]  = '{"w32_add_ovf",   5, 1'b0, 32'h7FFFFFFF,  32'h1,  1'b0, 32'h80000000,  1'b0, 1'b1};
        vecs[8]  = '{"w16_add_cin",   4, 1'b0, 32'hFFFF,      32'h0001, 1'b1, 32'h0001,    1'b1, 1'b0};
        vecs[9]  = '{"sub_cin_ign",   0, 1'b1, 32'h10,        32'h10, 1'b1, 32'h00,        1'b1, 1'b0};
        vecs[10] = '{"w32_sub_ovf",   5, 1'b1, 32'h80000000,  32'h1,  1'b0, 32'h7FFFFFFF,  1'b1, 1'b1};
        vecs[11] = '{"d2_sub_3c_5a",  3, 1'b1, 32'h3C,        32'h5A, 1'b0, 32'hE2,        1'b0, 1'b0};

        void'($urandom(`SEED));
        reset = 1'b1;
        start = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("reset_k%0d", k),
                64'({s_v[k], cout_v[k], ovf_v[k], busy_v[k], done_v[k], st_v[k]}), 64'd0);
        end

        // start already high when reset is released
        do_op("rst_start", 0, 1'b0, 32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].nm, vecs[i].k, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin,
                  vecs[i].s, vecs[i].cout, vecs[i].ovf, 1'b0, 1'b0);
        end

        // start pulses and operand changes while running must be ignored
        do_op("disturb", 0, 1'b0, 32'h12, 32'h34, 1'b1, 32'h47, 1'b0, 1'b0, 1'b1, 1'b0);

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        op = 1'b0; a_in = 32'h55; b_in = 32'h22; cin = 1'b0; start[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = '0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        #2 reset = 1'b1;
        #1;
        chk("mid_reset.s",    64'(s_v[0]),    64'd0);
        chk("mid_reset.flags", 64'({cout_v[0], ovf_v[0], busy_v[0], done_v[0], st_v[0]}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("mid_reset.discarded", 64'({s_v[0], busy_v[0], done_v[0]}), 64'd0);
        do_op("after_reset", 0, 1'b1, 32'h80, 32'h01, 1'b0, 32'h7F, 1'b1, 1'b1, 1'b0, 1'b0);

        // random regression
        rand_run(0, `NP);
        rand_run(3, `NP);
        rand_run(4, `NP);
        rand_run(5, `NP);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
